// File: rtl/reg_ctx_pkg.sv
// -----------------------------------------------------------------------------
// reg_ctx_pkg
// Shared definitions for the register-context save/restore engine:
//   - ctx_state_e : engine FSM states
//   - WORD_BYTES  : bytes per saved register slot in memory
//   - DEF_*       : default register-file geometry
//   - word_align  : force a byte address onto a word boundary
//   - slot_addr   : byte address of a save-area slot (modulo 2^32)
// -----------------------------------------------------------------------------
package reg_ctx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE_RD = 3'd1,
    SAVE_WR = 3'd2,
    REST_RD = 3'd3,
    REST_WR = 3'd4,
    FINISH  = 3'd5
  } ctx_state_e;

  localparam int WORD_BYTES    = 4;
  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_FIRST_REG = 1;

  // Clear the byte-offset bits so every slot is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Slot k lives at base + k*WORD_BYTES; the add wraps silently at 2^32.
  function automatic logic [31:0] slot_addr(input logic [31:0] base,
                                            input logic [31:0] slot);
    return base + (slot * 32'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/reg_context_ctrl_checker.sv
// -----------------------------------------------------------------------------
// reg_context_ctrl_checker
// Protocol assertions for reg_context_ctrl; bound alongside the engine in
// simulation. Purely observational.
// Ports (all inputs): CLK, RESET_N, BUSY, DONE, RF_OWN, RF_WRITE_EN,
//                     MEM_READ, MEM_WRITE
// -----------------------------------------------------------------------------
module reg_context_ctrl_checker (
  input logic CLK,
  input logic RESET_N,
  input logic BUSY,
  input logic DONE,
  input logic RF_OWN,
  input logic RF_WRITE_EN,
  input logic MEM_READ,
  input logic MEM_WRITE
);

  // Memory strobes are mutually exclusive.
  a_strobe_excl : assert property (@(posedge CLK) disable iff (!RESET_N)
    !(MEM_READ && MEM_WRITE))
    else $error("checker: MEM_READ and MEM_WRITE high together");

  // The datapath is owned exactly while the engine is busy.
  a_own_busy : assert property (@(posedge CLK) disable iff (!RESET_N)
    RF_OWN == BUSY)
    else $error("checker: RF_OWN differs from BUSY");

  // DONE is a single-cycle pulse issued while still busy, then idle.
  a_done_pulse : assert property (@(posedge CLK) disable iff (!RESET_N)
    DONE |-> BUSY ##1 (!DONE && !BUSY))
    else $error("checker: DONE pulse shape wrong");

  // Every side-effecting strobe happens only while busy.
  a_strobe_busy : assert property (@(posedge CLK) disable iff (!RESET_N)
    (RF_WRITE_EN || MEM_READ || MEM_WRITE) |-> BUSY)
    else $error("checker: strobe while not busy");

endmodule

// File: rtl/reg_context_ctrl.sv
// -----------------------------------------------------------------------------
// reg_context_ctrl
// Context save/restore engine for the CPU register file. A save copies
// registers FIRST_REG..NUM_REGS-1 into consecutive words of a memory save
// area; a restore copies them back into the register file.
//
// Ports:
//   CLK, RESET_N               clock, asynchronous active-low reset
//   SAVE_REQ, RESTORE_REQ      start requests, sampled only when idle
//   BASE_ADDR                  save-area byte address, captured at start
//   BUSY, DONE                 activity flag, one-cycle completion pulse
//   RF_OWN                     datapath routes RF ports from this block
//   RF_RADDR / RF_RDATA        register-file read port (read on falling edge)
//   RF_WADDR / RF_WDATA /
//   RF_WRITE_EN                register-file write port
//   MEM_ADDR / MEM_WDATA /
//   MEM_READ / MEM_WRITE /
//   MEM_RDATA / MEM_BUSYWAIT   data-memory port with stall
// All outputs are registered.
// -----------------------------------------------------------------------------
module reg_context_ctrl
  import reg_ctx_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int FIRST_REG = DEF_FIRST_REG,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              SAVE_REQ,
  input  logic              RESTORE_REQ,
  input  logic [31:0]       BASE_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              RF_OWN,
  output logic [ADDR_W-1:0] RF_RADDR,
  input  logic [DATA_W-1:0] RF_RDATA,
  output logic [ADDR_W-1:0] RF_WADDR,
  output logic [DATA_W-1:0] RF_WDATA,
  output logic              RF_WRITE_EN,
  output logic [31:0]       MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_BUSYWAIT
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  ctx_state_e        state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [31:0]       base_r;

  logic              last_s;
  logic [ADDR_W-1:0] next_idx_s;
  logic [31:0]       cur_slot_s;
  logic [31:0]       cur_addr_s;
  logic [31:0]       next_addr_s;

  // Slot address of the current register and of the one after it.
  always_comb begin
    last_s      = (idx_r == LAST_IDX);
    next_idx_s  = idx_r + IDX_ONE;
    cur_slot_s  = 32'(idx_r - FIRST_IDX);
    cur_addr_s  = slot_addr(base_r, cur_slot_s);
    next_addr_s = slot_addr(base_r, cur_slot_s + 32'd1);
  end

  // Engine FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= IDLE;
      idx_r       <= FIRST_IDX;
      base_r      <= 32'd0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      RF_OWN      <= 1'b0;
      RF_RADDR    <= '0;
      RF_WADDR    <= '0;
      RF_WDATA    <= '0;
      RF_WRITE_EN <= 1'b0;
      MEM_ADDR    <= 32'd0;
      MEM_WDATA   <= '0;
      MEM_READ    <= 1'b0;
      MEM_WRITE   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          DONE <= 1'b0;
          // Save has priority when both requests arrive together.
          if (SAVE_REQ) begin
            state_r  <= SAVE_RD;
            idx_r    <= FIRST_IDX;
            base_r   <= word_align(BASE_ADDR);
            BUSY     <= 1'b1;
            RF_OWN   <= 1'b1;
            RF_RADDR <= FIRST_IDX;
          end else if (RESTORE_REQ) begin
            // First memory read is issued straight from the start edge.
            state_r  <= REST_RD;
            idx_r    <= FIRST_IDX;
            base_r   <= word_align(BASE_ADDR);
            BUSY     <= 1'b1;
            RF_OWN   <= 1'b1;
            MEM_READ <= 1'b1;
            MEM_ADDR <= word_align(BASE_ADDR);
          end
        end

        SAVE_RD: begin
          // The register file answered on the falling edge; capture it now.
          state_r   <= SAVE_WR;
          MEM_WDATA <= RF_RDATA;
          MEM_ADDR  <= cur_addr_s;
          MEM_WRITE <= 1'b1;
        end

        SAVE_WR: begin
          if (!MEM_BUSYWAIT) begin
            MEM_WRITE <= 1'b0;
            if (last_s) begin
              state_r <= FINISH;
              DONE    <= 1'b1;
            end else begin
              state_r  <= SAVE_RD;
              idx_r    <= next_idx_s;
              RF_RADDR <= next_idx_s;
            end
          end
        end

        REST_RD: begin
          if (!MEM_BUSYWAIT) begin
            state_r     <= REST_WR;
            MEM_READ    <= 1'b0;
            RF_WDATA    <= MEM_RDATA;
            RF_WADDR    <= idx_r;
            RF_WRITE_EN <= 1'b1;
          end
        end

        REST_WR: begin
          RF_WRITE_EN <= 1'b0;
          if (last_s) begin
            state_r <= FINISH;
            DONE    <= 1'b1;
          end else begin
            state_r  <= REST_RD;
            idx_r    <= next_idx_s;
            MEM_READ <= 1'b1;
            MEM_ADDR <= next_addr_s;
          end
        end

        FINISH: begin
          state_r <= IDLE;
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          RF_OWN  <= 1'b0;
        end

        default: begin
          // Unreachable encodings fall back to a quiet idle.
          state_r     <= IDLE;
          idx_r       <= FIRST_IDX;
          BUSY        <= 1'b0;
          DONE        <= 1'b0;
          RF_OWN      <= 1'b0;
          RF_WRITE_EN <= 1'b0;
          MEM_READ    <= 1'b0;
          MEM_WRITE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_context_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_context_ctrl
// Self-checking bench for reg_context_ctrl. A behavioural register file and a
// sparse memory with programmable stalls surround the engine; expected
// transfer logs and cycle counts are computed from the save-area rules.
// -----------------------------------------------------------------------------
module tb_reg_context_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        SAVE_REQ = 1'b0;
  logic        RESTORE_REQ = 1'b0;
  logic [31:0] BASE_ADDR = 32'd0;
  logic        BUSY, DONE, RF_OWN;
  logic [4:0]  RF_RADDR, RF_WADDR;
  logic [31:0] RF_RDATA = 32'd0;
  logic [31:0] RF_WDATA;
  logic        RF_WRITE_EN;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_READ, MEM_WRITE;
  logic [31:0] MEM_RDATA = 32'd0;
  logic        MEM_BUSYWAIT = 1'b0;

  reg_context_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .SAVE_REQ(SAVE_REQ), .RESTORE_REQ(RESTORE_REQ),
    .BASE_ADDR(BASE_ADDR), .BUSY(BUSY), .DONE(DONE), .RF_OWN(RF_OWN),
    .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA), .RF_WADDR(RF_WADDR),
    .RF_WDATA(RF_WDATA), .RF_WRITE_EN(RF_WRITE_EN), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_RDATA(MEM_RDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  reg_context_ctrl_checker chk_i (
    .CLK(CLK), .RESET_N(RESET_N), .BUSY(BUSY), .DONE(DONE), .RF_OWN(RF_OWN),
    .RF_WRITE_EN(RF_WRITE_EN), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    bit rs; bit rr; logic [31:0] base; int bw; int exp_cycles; logic [31:0] exp_first;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] rf [32];
  logic [31:0] mem [logic [31:0]];
  wr_t         wlog[$];
  wr_t         rflog[$];
  logic [31:0] alog[$];

  int   bw_mode = 0;
  int   bw_len = 0;
  int   bw_cnt = 0;
  bit   acc_active = 1'b0;
  int   stall_total = 0;
  int   done_cnt = 0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [1:0]  prev_strb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory with stalls, register file and protocol monitors, all on the falling edge.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      prev_stall   = 1'b0;
      acc_active   = 1'b0;
      MEM_BUSYWAIT = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold addr/data", {MEM_ADDR, MEM_WDATA}, {prev_addr, prev_wdata});
        chk("hold strobe", {62'd0, MEM_READ, MEM_WRITE}, {62'd0, prev_strb});
      end
      prev_stall = 1'b0;
      if (MEM_READ || MEM_WRITE) begin
        chk("strobe excl", {63'd0, MEM_READ & MEM_WRITE}, 64'd0);
        if (!acc_active) begin
          acc_active = 1'b1;
          bw_cnt = 0;
          bw_len = (bw_mode < 0) ? int'($urandom_range(0, 2)) : bw_mode;
        end
        if (bw_cnt < bw_len) begin
          MEM_BUSYWAIT = 1'b1;
          bw_cnt++;
          stall_total++;
          prev_stall = 1'b1;
          prev_addr  = MEM_ADDR;
          prev_wdata = MEM_WDATA;
          prev_strb  = {MEM_READ, MEM_WRITE};
          MEM_RDATA  = 32'hDEAD_BEEF;
        end else begin
          MEM_BUSYWAIT = 1'b0;
          acc_active = 1'b0;
          alog.push_back(MEM_ADDR);
          if (MEM_WRITE) begin
            mem[MEM_ADDR] = MEM_WDATA;
            wlog.push_back('{MEM_ADDR, MEM_WDATA});
          end else begin
            MEM_RDATA = mem_rd(MEM_ADDR);
          end
        end
      end else begin
        MEM_BUSYWAIT = 1'b0;
        acc_active = 1'b0;
      end
      if (RF_WRITE_EN) begin
        rf[RF_WADDR] = RF_WDATA;
        rflog.push_back('{{27'd0, RF_WADDR}, RF_WDATA});
      end
      if (DONE) done_cnt++;
    end
    RF_RDATA = rf[RF_RADDR];
  end

  task automatic rst_outputs_zero(input string tag);
    chk({tag, " ctl"}, {52'd0, BUSY, DONE, RF_OWN, RF_WRITE_EN, MEM_READ, MEM_WRITE,
                        RF_RADDR, RF_WADDR}, 64'd0);
    chk({tag, " mem_addr"}, {32'd0, MEM_ADDR}, 64'd0);
    chk({tag, " wdata"}, {RF_WDATA, MEM_WDATA}, 64'd0);
  endtask

  // Issue one request and wait (bounded) for DONE; returns start-edge..DONE-edge cycles.
  task automatic run_op(input bit rs, input bit rr, input logic [31:0] base,
                        input int bw, input int inject, output int cycles, output int busy_drop);
    int start;
    wlog.delete(); rflog.delete(); alog.delete();
    stall_total = 0; done_cnt = 0; bw_mode = bw;
    cycles = -1; busy_drop = 0;
    @(negedge CLK);
    SAVE_REQ = rs; RESTORE_REQ = rr; BASE_ADDR = base;
    @(negedge CLK);
    start = cyc;
    SAVE_REQ = 1'b0; RESTORE_REQ = 1'b0; BASE_ADDR = $urandom;
    for (int n = 0; n < 2000; n++) begin
      if (DONE) begin
        cycles = cyc - start + 1;
        break;
      end
      if (!BUSY) busy_drop++;
      RESTORE_REQ = (n == inject);
      @(negedge CLK);
    end
    RESTORE_REQ = 1'b0;
    @(negedge CLK);
    chk("post idle", {62'd0, BUSY, DONE}, 64'd0);
  endtask

  // Run an operation and compare its transfers against the save-area model.
  task automatic do_op(input string tag, input bit rs, input bit rr, input logic [31:0] base,
                       input int bw, input int inject, input int exp_cycles,
                       input logic [31:0] exp_first);
    wr_t exp_q[$];
    logic [31:0] ab, a;
    int cycles, busy_drop, exp_c;
    ab = base & 32'hFFFF_FFFC;
    for (int k = 0; k < 31; k++) begin
      a = ab + 32'(4 * k);
      exp_q.push_back('{a, rs ? rf[k + 1] : mem_rd(a)});
    end
    run_op(rs, rr, base, bw, inject, cycles, busy_drop);
    exp_c = (exp_cycles >= 0) ? exp_cycles : 63 + stall_total;
    chk({tag, " cycles"}, 64'(cycles), 64'(exp_c));
    chk({tag, " busy held"}, 64'(busy_drop), 64'd0);
    chk({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, " accesses"}, 64'(alog.size()), 64'd31);
    chk({tag, " first addr"}, {32'd0, alog[0]}, {32'd0, exp_first});
    for (int k = 0; k < 31; k++) chk({tag, " addr"}, {32'd0, alog[k]}, {32'd0, exp_q[k].a});
    if (rs) begin
      chk({tag, " mem writes"}, 64'(wlog.size()), 64'd31);
      chk({tag, " no rf writes"}, 64'(rflog.size()), 64'd0);
      for (int k = 0; k < 31; k++)
        chk({tag, " save data"}, {wlog[k].a, wlog[k].d}, {exp_q[k].a, exp_q[k].d});
    end else begin
      chk({tag, " rf writes"}, 64'(rflog.size()), 64'd31);
      chk({tag, " no mem writes"}, 64'(wlog.size()), 64'd0);
      for (int k = 0; k < 31; k++)
        chk({tag, " rest data"}, {rflog[k].a, rflog[k].d}, {32'(k + 1), exp_q[k].d});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    logic [31:0] snap [32];
    logic [31:0] rb;
    bit found;

    vt[0] = '{1'b1, 1'b0, 32'h0000_0100,  0,  63, 32'h0000_0100};
    vt[1] = '{1'b0, 1'b1, 32'h0000_0200,  0,  63, 32'h0000_0200};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0300,  3, 156, 32'h0000_0300};
    vt[3] = '{1'b0, 1'b1, 32'h0000_0300,  3, 156, 32'h0000_0300};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0103,  0,  63, 32'h0000_0100};
    vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFF0,  1,  94, 32'hFFFF_FFF0};
    vt[6] = '{1'b1, 1'b1, 32'h0000_0500,  0,  63, 32'h0000_0500};

    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 32'h11);
    for (int k = 0; k < 31; k++) mem[32'h200 + 32'(4 * k)] = 32'hA000_0000 + 32'(k);

    repeat (3) @(negedge CLK);
    rst_outputs_zero("reset");
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("idle busy", {63'd0, BUSY}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].rs, vt[i].rr, vt[i].base, vt[i].bw, -1,
            vt[i].exp_cycles, vt[i].exp_first);
      if (i == 0) chk("save last word", {wlog[30].a, wlog[30].d}, {32'h178, 32'h20F});
      if (i == 1) begin
        chk("rest x1", {32'd0, rf[1]}, {32'd0, 32'hA000_0000});
        chk("rest x31", {32'd0, rf[31]}, {32'd0, 32'hA000_001E});
        chk("x0 untouched", {32'd0, rf[0]}, 64'd0);
      end
      if (i == 5) chk("wrap addr", {32'd0, alog[4]}, 64'd0);
    end

    // A restore pulse in the middle of a save is dropped, not queued.
    do_op("inject", 1'b1, 1'b0, 32'h0000_0600, 0, 20, 63, 32'h0000_0600);
    repeat (3) @(negedge CLK);
    chk("inject ignored busy", {63'd0, BUSY}, 64'd0);
    chk("inject ignored rf", 64'(rflog.size()), 64'd0);

    // Reset while the write of register 10 is stalled.
    wlog.delete(); rflog.delete(); alog.delete(); done_cnt = 0; bw_mode = 2;
    @(negedge CLK);
    SAVE_REQ = 1'b1; BASE_ADDR = 32'h0000_0400;
    @(negedge CLK);
    SAVE_REQ = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (MEM_WRITE && MEM_ADDR == 32'h0000_0424) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("reached idx10", {63'd0, found}, 64'd1);
    #2 RESET_N = 1'b0;
    #1 rst_outputs_zero("midop reset");
    chk("midop writes", 64'(wlog.size()), 64'd9);
    chk("midop no done", 64'(done_cnt), 64'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    do_op("after reset", 1'b1, 1'b0, 32'h0000_0400, 0, -1, 63, 32'h0000_0400);

    // Random save / scramble / restore round trips with random stalls.
    for (int r = 0; r < 4; r++) begin
      rb = $urandom;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < 32; i++) snap[i] = rf[i];
      do_op($sformatf("rnd save%0d", r), 1'b1, 1'b0, rb, -1, -1, -1, rb & 32'hFFFF_FFFC);
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      do_op($sformatf("rnd rest%0d", r), 1'b0, 1'b1, rb, -1, -1, -1, rb & 32'hFFFF_FFFC);
      for (int i = 0; i < 32; i++)
        chk($sformatf("rnd rf%0d", i), {32'd0, rf[i]}, {32'd0, snap[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
